// File: rtl/decoder_seq_n_if.sv
// Bus bundle for decoder_seq_n: select/mode inputs and decoded/scan outputs.
// master drives the selects, slave is the decoder itself.
interface decoder_seq_n_if #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned NUM_OUT = 8
);
  logic               en;
  logic [1:0]         mode;
  logic               in_valid;
  logic [SEL_W-1:0]   in_sel;
  logic [NUM_OUT-1:0] out_dec;
  logic               out_valid;
  logic               err;
  logic [SEL_W-1:0]   scan_idx;
  logic               scan_wrap;

  modport master (
    output en, mode, in_valid, in_sel,
    input  out_dec, out_valid, err, scan_idx, scan_wrap
  );

  modport slave (
    input  en, mode, in_valid, in_sel,
    output out_dec, out_valid, err, scan_idx, scan_wrap
  );
endinterface

// File: rtl/decoder_seq_n.sv
// Registered N-to-M decoder with one-hot, thermometer and autonomous scan modes.
// Scan steps a one-hot strobe across the outputs, holding each step DWELL cycles.
module decoder_seq_n #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned DWELL   = 4,
  parameter bit          ACT_LOW = 1'b0
) (
  input logic            clk_i,
  input logic            rst_i,
  decoder_seq_n_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_SCAN
  } state_e;

  localparam int unsigned        DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]    DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   IDX_LAST   = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W:0]     NUM_OUT_X  = (SEL_W + 1)'(NUM_OUT);
  localparam logic [NUM_OUT-1:0] INACTIVE   = ACT_LOW ? '1 : '0;

  state_e             state_q, state_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               wrap_q, wrap_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic               resume_q, resume_d;

  logic scan_req;
  logic thermo_req;
  logic sel_oob;

  assign scan_req   = (bus.mode == 2'b10);
  assign thermo_req = (bus.mode == 2'b01);
  assign sel_oob    = ({1'b0, bus.in_sel} >= NUM_OUT_X);

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      v[i] = (i == 32'(s));
    end
    return v;
  endfunction

  function automatic logic [NUM_OUT-1:0] thermo(input logic [SEL_W-1:0] s);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      v[i] = (i <= 32'(s));
    end
    return v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = S_IDLE;
    end else if (scan_req) begin
      state_d = S_SCAN;
    end else begin
      state_d = S_DECODE;
    end
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    idx_d       = idx_q;
    wrap_d      = 1'b0;
    dwell_d     = dwell_q;
    resume_d    = resume_q;
    case (state_d)
      S_SCAN: begin
        resume_d    = 1'b0;
        out_valid_d = 1'b1;
        // Continue counting when already scanning or when re-enabled after
        // scan was paused by en=0; any other entry restarts from step 0.
        if (state_q == S_SCAN || resume_q) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end else begin
          idx_d   = '0;
          dwell_d = '0;
        end
        out_d = onehot(idx_d) ^ INACTIVE;
      end
      S_DECODE: begin
        resume_d = 1'b0;
        if (bus.in_valid) begin
          if (sel_oob) begin
            out_d       = INACTIVE;
            out_valid_d = 1'b0;
            err_d       = 1'b1;
          end else begin
            out_d       = (thermo_req ? thermo(bus.in_sel) : onehot(bus.in_sel)) ^ INACTIVE;
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        out_d       = INACTIVE;
        out_valid_d = 1'b0;
        resume_d    = resume_q | (state_q == S_SCAN);
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= INACTIVE;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wrap_q      <= 1'b0;
      dwell_q     <= '0;
      resume_q    <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      wrap_q      <= wrap_d;
      dwell_q     <= dwell_d;
      resume_q    <= resume_d;
    end
  end

  assign bus.out_dec   = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.scan_idx  = idx_q;
  assign bus.scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_seq_n.sv
// Bench for decoder_seq_n: three parameterisations driven in lockstep and checked
// every cycle against a phase-based behavioural model, plus literal spot checks.
module tb_decoder_seq_n;

  logic       clk = 1'b0;
  logic       rst, en, iv;
  logic [1:0] mode;
  logic [2:0] sel;

  always #5 clk = ~clk;

  decoder_seq_n_if #(.SEL_W(3), .NUM_OUT(8)) b0 ();
  decoder_seq_n_if #(.SEL_W(3), .NUM_OUT(6)) b1 ();
  decoder_seq_n_if #(.SEL_W(3), .NUM_OUT(8)) b2 ();

  assign b0.en = en;   assign b0.mode = mode; assign b0.in_valid = iv; assign b0.in_sel = sel;
  assign b1.en = en;   assign b1.mode = mode; assign b1.in_valid = iv; assign b1.in_sel = sel;
  assign b2.en = en;   assign b2.mode = mode; assign b2.in_valid = iv; assign b2.in_sel = sel;

  decoder_seq_n #(.SEL_W(3), .NUM_OUT(8), .DWELL(4), .ACT_LOW(1'b0))
    u0 (.clk_i(clk), .rst_i(rst), .bus(b0.slave));
  decoder_seq_n #(.SEL_W(3), .NUM_OUT(6), .DWELL(3), .ACT_LOW(1'b0))
    u1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));
  decoder_seq_n #(.SEL_W(3), .NUM_OUT(8), .DWELL(2), .ACT_LOW(1'b1))
    u2 (.clk_i(clk), .rst_i(rst), .bus(b2.slave));

  logic [7:0] a_out [3];
  logic       a_ov  [3];
  logic       a_err [3];
  logic       a_wrap[3];
  logic [2:0] a_idx [3];

  assign a_out[0] = b0.out_dec;            assign a_out[1] = {2'b00, b1.out_dec};
  assign a_out[2] = b2.out_dec;
  assign a_ov[0]  = b0.out_valid;          assign a_ov[1]  = b1.out_valid;
  assign a_ov[2]  = b2.out_valid;
  assign a_err[0] = b0.err;                assign a_err[1] = b1.err;
  assign a_err[2] = b2.err;
  assign a_wrap[0] = b0.scan_wrap;         assign a_wrap[1] = b1.scan_wrap;
  assign a_wrap[2] = b2.scan_wrap;
  assign a_idx[0] = b0.scan_idx;           assign a_idx[1] = b1.scan_idx;
  assign a_idx[2] = b2.scan_idx;

  // Model: scan position is a single phase counter over NUM_OUT*DWELL cycles.
  int unsigned NO[3] = '{8, 6, 8};
  int unsigned DW[3] = '{4, 3, 2};
  bit          AL[3] = '{1'b0, 1'b0, 1'b1};

  int          m_st [3];   // 0 idle, 1 decode, 2 scan
  bit          m_res[3];   // paused out of scan by en=0
  int unsigned m_ph [3];
  logic [7:0]  m_out[3];
  bit          m_ov [3], m_err[3], m_wrap[3];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk    = 1'b0;

  function automatic logic [7:0] inact(input int k);
    int unsigned mask;
    mask = (1 << NO[k]) - 1;
    return AL[k] ? 8'(mask) : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        int s;
        s = int'(sel);
        if (rst) begin
          m_st[k] = 0; m_res[k] = 1'b0; m_ph[k] = 0;
          m_out[k] = inact(k); m_ov[k] = 1'b0; m_err[k] = 1'b0; m_wrap[k] = 1'b0;
        end else begin
          m_err[k] = 1'b0; m_wrap[k] = 1'b0;
          if (!en) begin
            m_res[k] = m_res[k] || (m_st[k] == 2);
            m_st[k]  = 0;
            m_out[k] = inact(k); m_ov[k] = 1'b0;
          end else if (mode == 2'b10) begin
            if (m_st[k] == 2 || (m_st[k] == 0 && m_res[k])) begin
              m_ph[k]   = (m_ph[k] + 1) % (NO[k] * DW[k]);
              m_wrap[k] = (m_ph[k] == 0);
            end else begin
              m_ph[k] = 0;
            end
            m_st[k] = 2; m_res[k] = 1'b0;
            m_out[k] = 8'(1 << (m_ph[k] / DW[k])) ^ inact(k);
            m_ov[k]  = 1'b1;
          end else begin
            m_st[k] = 1; m_res[k] = 1'b0;
            if (iv) begin
              if (s >= int'(NO[k])) begin
                m_out[k] = inact(k); m_ov[k] = 1'b0; m_err[k] = 1'b1;
              end else begin
                m_out[k] = 8'((mode == 2'b01) ? ((1 << (s + 1)) - 1) : (1 << s)) ^ inact(k);
                m_ov[k]  = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk) begin
        for (int k = 0; k < 3; k++) begin
          check($sformatf("u%0d.out", k),  a_out[k],  m_out[k]);
          check($sformatf("u%0d.ov", k),   a_ov[k],   m_ov[k]);
          check($sformatf("u%0d.err", k),  a_err[k],  m_err[k]);
          check($sformatf("u%0d.wrap", k), a_wrap[k], m_wrap[k]);
          check($sformatf("u%0d.idx", k),  a_idx[k],  m_ph[k] / DW[k]);
          check($sformatf("u%0d.err_wrap_excl", k), a_err[k] & a_wrap[k], 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_strobe;
    int         cnt;
    rst = 1'b1; en = 1'b0; mode = 2'b00; iv = 1'b0; sel = 3'd0;
    repeat (2) @(negedge clk);
    chk = 1'b1;
    check("rst_out_u0", a_out[0], 8'h00);
    check("rst_ov_u0",  a_ov[0],  0);
    check("rst_idx_u0", a_idx[0], 0);
    check("rst_out_u2", a_out[2], 8'hFF);

    rst = 1'b0; en = 1'b1; mode = 2'b00; sel = 3'd5; iv = 1'b1;
    @(negedge clk);
    check("onehot5_out", a_out[0], 8'b0010_0000);
    check("onehot5_ov",  a_ov[0],  1);
    check("onehot5_model", m_out[0], 8'b0010_0000);

    mode = 2'b01; sel = 3'd3;
    @(negedge clk);
    check("thermo3_out", a_out[0], 8'b0000_1111);
    check("thermo3_model", m_out[0], 8'b0000_1111);
    iv = 1'b0; sel = 3'd6;
    @(negedge clk);
    check("hold_out", a_out[0], 8'b0000_1111);
    check("hold_ov",  a_ov[0],  1);

    mode = 2'b00; iv = 1'b1; sel = 3'd7;
    @(negedge clk);
    check("oob_out_u1", a_out[1], 8'h00);
    check("oob_ov_u1",  a_ov[1],  0);
    check("oob_err_u1", a_err[1], 1);
    check("inrange_out_u0", a_out[0], 8'h80);
    iv = 1'b0;
    @(negedge clk);
    check("oob_err_pulse_u1", a_err[1], 0);

    iv = 1'b1; sel = 3'd0;
    @(negedge clk);
    check("actlow_onehot0_u2", a_out[2], 8'hFE);

    iv = 1'b0; mode = 2'b10;
    @(negedge clk);
    for (int c = 0; c <= 32; c++) begin
      exp_strobe = 8'h01 << ((c / 4) % 8);
      check("scan_seq_u0",  a_out[0], exp_strobe);
      check("scan_wrap_u0", a_wrap[0], (c == 32) ? 1 : 0);
      @(negedge clk);
    end

    for (int t = 0; t < 64 && a_idx[0] != 3'd3; t++) @(negedge clk);
    check("reach_idx3", a_idx[0], 3);
    @(negedge clk);
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("paused_out_u0", a_out[0], 8'h00);
      check("paused_idx_u0", a_idx[0], 3);
    end
    en = 1'b1;
    cnt = 0;
    @(negedge clk);
    for (int t = 0; t < 10 && a_idx[0] == 3'd3 && a_out[0] == 8'h08; t++) begin
      cnt++;
      @(negedge clk);
    end
    check("resume_remaining_dwell", cnt, 2);

    rst = 1'b1;
    @(negedge clk);
    check("midscan_rst_out_u2", a_out[2], 8'hFF);
    check("midscan_rst_idx_u2", a_idx[2], 0);
    rst = 1'b0;

    repeat (600) begin
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      iv  = 1'($urandom_range(0, 1));
      sel = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end

    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
